// File: rtl/basic_one_bit_adder_pkg.sv
// Shared types and the single-bit full-add function used by the ripple-carry
// adder cells.
package basic_one_bit_adder_pkg;

  typedef struct packed {
    logic co;
    logic s;
  } fa_out_t;

  function automatic fa_out_t full_add(input logic a, input logic b, input logic ci);
    fa_out_t r;
    r.s  = a ^ b ^ ci;
    r.co = (a & b) | (ci & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/basic_one_bit_adder_full_adder_cell.sv
// Combinational one-bit full adder; one link of the ripple-carry chain.
module full_adder_cell
  import basic_one_bit_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_out_t r;

  always_comb begin
    r  = full_add(a, b, ci);
    s  = r.s;
    co = r.co;
  end

endmodule

// File: rtl/basic_one_bit_adder.sv
// WIDTH-bit ripple-carry adder with an optional output register stage.
// The default WIDTH=1 gives the canonical one-bit clocked full adder.
module basic_one_bit_adder #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  // Last in the list so legacy positional six-port instances still line up.
  input  logic             rst_n
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    always_comb begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is synchronous and wins over data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign sum  = s;
    assign cout = c[WIDTH];
  end

endmodule

// File: tb/tb_basic_one_bit_adder.sv
// Directed self-checking bench: registered 1-bit and 4-bit instances sharing
// clk/rst_n, plus a combinational 1-bit instance on a stopped clock.
module tb_basic_one_bit_adder;

  logic       clk = 1'b0;
  logic       clk_stop = 1'b0;
  logic       rst_n;
  logic       a1, b1, cin1;
  logic       sum1, cout1;
  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4;
  logic       ac, bc, cinc, sumc, coutc;

  int checks = 0;
  int errors = 0;

  always #35 clk = ~clk;

  basic_one_bit_adder #(.WIDTH(1), .OUT_REG(1'b1)) dut1 (
    .cin(cin1), .a(a1), .b(b1), .clk(clk), .sum(sum1), .cout(cout1), .rst_n(rst_n)
  );

  basic_one_bit_adder #(.WIDTH(4), .OUT_REG(1'b1)) dut4 (
    .cin(cin4), .a(a4), .b(b4), .clk(clk), .sum(sum4), .cout(cout4), .rst_n(rst_n)
  );

  basic_one_bit_adder #(.WIDTH(1), .OUT_REG(1'b0)) dutc (
    .cin(cinc), .a(ac), .b(bc), .clk(clk_stop), .sum(sumc), .cout(coutc), .rst_n(1'b1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic [2:0] abc);
    {a1, b1, cin1} = abc;
  endtask

  task automatic rise;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive1(3'b111);
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    ac = 1'b0; bc = 1'b0; cinc = 1'b0;

    // 1. reset held for two edges with all-ones inputs
    rise();
    check("reset_edge1", {6'b0, cout1, sum1}, 8'b00);
    rise();
    check("reset_edge2", {6'b0, cout1, sum1}, 8'b00);
    check("reset_w4", {3'b0, cout4, sum4}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rise();
    check("reset_release", {6'b0, cout1, sum1}, 8'b11);

    // 2. exhaustive truth table; expected = popcount of {a,b,cin}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      drive1(v);
      rise();
      check($sformatf("truth_%b", v), {6'b0, cout1, sum1},
            8'(int'(v[2]) + int'(v[1]) + int'(v[0])));
    end

    // 3. decoys applied at the falling edge must not reach the outputs
    @(negedge clk); drive1(3'b000); rise();
    check("fall_seq0", {6'b0, cout1, sum1}, 8'b00);
    @(negedge clk); drive1(3'b111); #1;
    check("fall_hold0", {6'b0, cout1, sum1}, 8'b00);
    #16 drive1(3'b110); rise();
    check("fall_seq1", {6'b0, cout1, sum1}, 8'b10);
    @(negedge clk); drive1(3'b100); #1;
    check("fall_hold1", {6'b0, cout1, sum1}, 8'b10);
    #16 drive1(3'b001); rise();
    check("fall_seq2", {6'b0, cout1, sum1}, 8'b01);
    @(negedge clk); drive1(3'b110); #1;
    check("fall_hold2", {6'b0, cout1, sum1}, 8'b01);
    #16 drive1(3'b111); rise();
    check("fall_seq3", {6'b0, cout1, sum1}, 8'b11);
    @(negedge clk); drive1(3'b000); #1;
    check("fall_hold3", {6'b0, cout1, sum1}, 8'b11);
    rise();
    check("fall_seq4", {6'b0, cout1, sum1}, 8'b00);

    // 4. hold 101 for three cycles, also checked mid-cycle
    @(negedge clk); drive1(3'b101);
    for (int k = 0; k < 3; k++) begin
      rise();
      check($sformatf("hold_rise%0d", k), {6'b0, cout1, sum1}, 8'b10);
      @(negedge clk); #1;
      check($sformatf("hold_fall%0d", k), {6'b0, cout1, sum1}, 8'b10);
    end

    // reset priority over data, then mid-stream release captures inputs
    drive1(3'b110);
    rst_n = 1'b0;
    rise();
    check("reset_priority", {6'b0, cout1, sum1}, 8'b00);
    @(negedge clk); rst_n = 1'b1;
    rise();
    check("reset_midstream", {6'b0, cout1, sum1}, 8'b10);

    // 5. four-bit instance
    @(negedge clk); a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    rise();
    check("w4_f_0_1", {3'b0, cout4, sum4}, 8'h10);
    @(negedge clk); a4 = 4'h9; b4 = 4'h6; cin4 = 1'b0;
    rise();
    check("w4_9_6_0", {3'b0, cout4, sum4}, 8'h0F);
    @(negedge clk); a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    rise();
    check("w4_wrap", {3'b0, cout4, sum4}, 8'h1F);
    @(negedge clk); a4 = 4'h5; b4 = 4'h3; cin4 = 1'b1;
    rise();
    check("w4_5_3_1", {3'b0, cout4, sum4}, 8'h09);

    // 6. combinational instance, clock stopped
    ac = 1'b1; bc = 1'b0; cinc = 1'b1; #1;
    check("comb_101", {6'b0, coutc, sumc}, 8'b10);
    ac = 1'b0; bc = 1'b0; cinc = 1'b0; #1;
    check("comb_000", {6'b0, coutc, sumc}, 8'b00);
    ac = 1'b1; bc = 1'b1; cinc = 1'b1; #1;
    check("comb_111", {6'b0, coutc, sumc}, 8'b11);
    ac = 1'b0; bc = 1'b1; cinc = 1'b0; #1;
    check("comb_010", {6'b0, coutc, sumc}, 8'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/basic_one_bit_adder.md
Name: basic_one_bit_adder

Overview:
Clocked full adder. It samples a, b and cin on the rising edge of clk and presents the registered sum and carry-out. The block is a leaf datapath cell used as a simple DUT for waveform/assertion tooling and as a building block for wider ripple adders. A WIDTH parameter generalises it to an N-bit registered ripple-carry adder. The default of 1 gives the canonical one-bit cell.

Parameters:
WIDTH, 1, operand width in bits; must be >= 1.
OUT_REG, 1, 1 = sum/cout registered on rising clk; 0 = purely combinational outputs (clk/rst_n unused).

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  synchronous active-low reset
cin  input  1  carry-in
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sum  output  WIDTH  registered sum bits
cout  output  1  registered carry-out

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Declaration order is cin, a, b, clk, sum, cout, rst_n. rst_n is appended last so that existing positional six-port instantiations remain order-compatible; such instances must tie rst_n high.
- Arithmetic: {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation before the carry.
- Internal carry chain: c[0] = cin.
- Per bit i: s[i] = a[i] ^ b[i] ^ c[i], and c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
- Carry-out: cout = c[WIDTH].
- OUT_REG=1, on each rising clk:
  - if rst_n == 0: sum <= 0 and cout <= 0;
  - else: sum <= s and cout <= c[WIDTH].
- Latency with OUT_REG=1: one cycle. Outputs reflect the inputs sampled at the most recent rising edge.
- Outputs hold their value between rising edges. Input changes on the falling edge or mid-cycle have no effect until the next rising edge.
- Reset value: sum = 0, cout = 0 after the first rising edge with rst_n low.
- Before the first edge, outputs are X in simulation. An implementation may initialise the registers to 0 for simulation.
- Reset has priority over data when both apply at the same edge. Deasserting rst_n mid-stream causes capture of the current inputs at the next rising edge.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, cout = 1. No overflow flag.
- OUT_REG=0: sum and cout are continuous functions of a, b and cin; clk and rst_n are ignored.
- No handshake. The block accepts a new operand set every cycle.

Decomposition:
- No shared package needed. WIDTH and OUT_REG are local parameters of the block only.
- One natural sub-module, full_adder_cell, with ports a, b, ci, s, co (combinational). It is instantiated WIDTH times via generate to form the ripple chain.
- The output register stage lives in basic_one_bit_adder.

Test Plan:
(WIDTH=1 and OUT_REG=1 unless stated. Clock period 70 time units; inputs change mid-period, half a period before the rising edge.)
1. Reset: hold rst_n=0 for 2 edges with a=1, b=1, cin=1 -> sum=0, cout=0. Release rst_n -> next edge gives sum=1, cout=1.
2. Exhaustive truth table: apply all 8 (a, b, cin) combinations, one per cycle -> after each edge, {cout, sum} equals a+b+cin. For example:
   - 000 -> 0,0
   - 100 -> 1,0
   - 110 -> 0,1
   - 111 -> 1,1
   - 001 -> 1,0
3. Falling-edge stability: sequence 000 @rise, then 110 @rise, then 001 @rise, then 111 @rise, then 000 @rise, with a different combination (e.g. 111, 100) present at each intervening fall. Required outputs after each rising edge: (0,0), (0,1), (1,0), (1,1), (0,0). Outputs must not change at the falling edges.
4. Hold: keep inputs constant at 101 for 3 cycles -> sum=0 and cout=1 stay stable; no glitch on the register outputs.
5. WIDTH=4: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1. Then a=4'h9, b=4'h6, cin=0 -> sum=4'hF, cout=0.
6. OUT_REG=0, WIDTH=1: a=1, b=0, cin=1 with clk stopped -> sum=0, cout=1 immediately.
